// File: rtl/mem_access_ctrl.sv
// Memory access stage: holds MAR, runs one req/ack read or write per request and
// returns read data toward MDR. Optional REQ watchdog enabled by `define MEMIF_TIMEOUT_EN.
module mem_access_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              MARin,
   input  logic [31:0]       BusMuxOut,
   input  logic              Read,
   input  logic              Write,
   input  logic [31:0]       MDRMuxIn,
   output logic [31:0]       Mdatain,
   output logic              MDRRead,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] mar_reg;
   logic [31:0]       mdatain_reg;
   logic [31:0]       wdata_reg;
   logic              we_reg;
   logic              err_reg;
   logic              timeout_hit;

   // Only the low ADDR_W bits of the bus address memory.
   logic bus_hi_unused;
   assign bus_hi_unused = |BusMuxOut[31:ADDR_W];

`ifdef MEMIF_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_reg <= '0;
      end else if (state_reg != ST_REQ) begin
         cnt_reg <= '0;
      end else if (!mem_ack) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // An ack arriving on the final allowed cycle takes priority over the abort.
   assign timeout_hit = (state_reg == ST_REQ) && !mem_ack
                        && (cnt_reg == CNT_W'(TIMEOUT - 1));
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (Read | Write)          state_next = ST_REQ;
         ST_REQ:  if (mem_ack | timeout_hit) state_next = ST_DONE;
         ST_DONE:                            state_next = ST_IDLE;
         default:                            state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mar_reg     <= '0;
         mdatain_reg <= '0;
         wdata_reg   <= '0;
         we_reg      <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (MARin) begin
                  mar_reg <= BusMuxOut[ADDR_W-1:0];
               end
               if (Read | Write) begin
                  wdata_reg <= MDRMuxIn;
                  we_reg    <= Write & ~Read;
                  err_reg   <= 1'b0;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  if (!we_reg) begin
                     mdatain_reg <= mem_rdata;
                  end
               end else if (timeout_hit) begin
                  mdatain_reg <= '0;
                  err_reg     <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode registered state only, so no input reaches an output combinationally.
   always_comb begin
      mem_req   = (state_reg == ST_REQ);
      busy      = (state_reg != ST_IDLE);
      done      = (state_reg == ST_DONE);
      MDRRead   = (state_reg == ST_DONE) & ~we_reg & ~err_reg;
      err       = (state_reg == ST_DONE) & err_reg;
      mem_we    = we_reg;
      mem_addr  = mar_reg;
      mem_wdata = wdata_reg;
      Mdatain   = mdatain_reg;
   end

endmodule
